// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute and drives datapath
// enables and muxes. Memory waits are bounded, and a fault halts the machine until reset.
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [3:0]  state,
    output logic [1:0]  fault,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // Last tolerated wait: the MEM_TIMEOUT-th idle cycle in a request state halts.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      cur_state, nxt_state;
    logic [1:0]  fault_r, fault_nxt;
    logic [7:0]  wait_cnt;
    logic [31:0] count_r;
    logic        rdy;
    logic        timed_out;

    // While reset is held, a ready from memory must not produce FETCH write strobes.
    assign rdy       = mem_ready & ~rst;
    assign timed_out = ~rdy && (wait_cnt == WAIT_LAST);

    always_comb begin
        nxt_state  = cur_state;
        fault_nxt  = fault_r;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        case (cur_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (rdy) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    nxt_state = S_DECODE;
                end else if (timed_out) begin
                    nxt_state = S_HALT;
                    fault_nxt = FAULT_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYPE:     nxt_state = S_EXEC;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_J:         nxt_state = S_JUMP;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    default: begin
                        nxt_state = S_HALT;
                        fault_nxt = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (rdy) begin
                    nxt_state = S_MEMWB;
                end else if (timed_out) begin
                    nxt_state = S_HALT;
                    fault_nxt = FAULT_TIMEOUT;
                end
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (rdy) begin
                    nxt_state = S_FETCH;
                end else if (timed_out) begin
                    nxt_state = S_HALT;
                    fault_nxt = FAULT_TIMEOUT;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                nxt_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_write  = zero;
                nxt_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src    = 2'b10;
                pc_write  = 1'b1;
                nxt_state = S_FETCH;
            end
            S_HALT: begin
                nxt_state = S_HALT;
            end
            default: begin
                nxt_state = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_FETCH;
            fault_r   <= FAULT_NONE;
            wait_cnt  <= 8'd0;
            count_r   <= 32'd0;
        end else begin
            cur_state <= nxt_state;
            fault_r   <= fault_nxt;
            // Counter restarts whenever the state changes, so each request state begins at 0.
            if (nxt_state != cur_state)
                wait_cnt <= 8'd0;
            else if (mem_req && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            if (nxt_state == S_FETCH && cur_state != S_FETCH)
                count_r <= count_r + 32'd1;
        end
    end

    assign state       = cur_state;
    assign fault       = fault_r;
    assign instr_count = count_r;

endmodule
